// File: rtl/g_arb_pkg.sv
// Shared types and constants for the g_arb4rr round-robin arbiter.
// Optional feature macro used by this slice: G_ARB4_LOCK_EN.
package g_arb_pkg;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  // Width needed to hold 0..quantum, never narrower than one bit.
  function automatic int cnt_w(input int quantum);
    int w;
    w = 1;
    while ((1 << w) < (quantum + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/g_rr_pick4.sv
// Combinational round-robin picker: rotate requests so PTR sits in slot 0,
// take the first set slot, then add PTR back to get the absolute index.
module g_rr_pick4
  import g_arb_pkg::*;
(
  input  logic [NREQ-1:0] REQ,
  input  logic [IDW-1:0]  PTR,
  output logic [IDW-1:0]  PICK,
  output logic            ANY
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [NREQ-1:0]   sel;
  logic [IDW-1:0]    off;

  assign dbl = {REQ, REQ};
  assign rot = dbl[PTR +: NREQ];

  // Each slot wins only when every earlier slot is idle.
  assign sel[0] = rot[0];
  assign sel[1] = ~rot[0] & rot[1];
  assign sel[2] = ~rot[0] & ~rot[1] & rot[2];
  assign sel[3] = ~rot[0] & ~rot[1] & ~rot[2] & rot[3];

  assign off  = {sel[2] | sel[3], sel[1] | sel[3]};
  assign PICK = PTR + off;
  assign ANY  = |REQ;

endmodule

// File: rtl/g_arb4rr.sv
// Four-requester round-robin arbiter with registered one-hot grant,
// one-cycle break-before-make gap and optional hold quantum.
// Define G_ARB4_LOCK_EN to add the LOCK input that suppresses preemption.
module g_arb4rr
  import g_arb_pkg::*;
#(
  parameter int unsigned QUANTUM    = 8,
  parameter int unsigned PRIO_RESET = 0
) (
  input  logic            CK,
  input  logic            CDN,
  input  logic            EN,
  input  logic [NREQ-1:0] REQ,
`ifdef G_ARB4_LOCK_EN
  input  logic            LOCK,
`endif
  output logic [NREQ-1:0] GNT,
  output logic            GV,
  output logic [IDW-1:0]  GID
);

  localparam int             CW      = cnt_w(int'(QUANTUM));
  localparam logic [CW-1:0]  QMAX    = CW'(QUANTUM);
  localparam logic [IDW-1:0] PTR_RST = IDW'(PRIO_RESET);

  state_e          state_q, state_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            gv_q, gv_d;
  logic [IDW-1:0]  gid_q, gid_d;

  logic [IDW-1:0]  pick;
  logic            any;
  logic [NREQ-1:0] owner_oh;
  logic            lock_on;
  logic            preempt;

  g_rr_pick4 u_pick (
    .REQ  (REQ),
    .PTR  (ptr_q),
    .PICK (pick),
    .ANY  (any)
  );

`ifdef G_ARB4_LOCK_EN
  assign lock_on = LOCK;
`else
  assign lock_on = 1'b0;
`endif

  assign owner_oh = NREQ'(1) << gid_q;
  assign preempt  = (QUANTUM != 0) && (cnt_q == QMAX) &&
                    (|(REQ & ~owner_oh)) && !lock_on;

  // Next-state logic: GAP arbitrates exactly like IDLE; release and
  // quantum expiry share one path, so a coincident drop is just a release.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    gv_d    = gv_q;
    gid_d   = gid_q;
    case (state_q)
      ST_GRANT: begin
        if (!REQ[gid_q] || preempt) begin
          gnt_d   = '0;
          gv_d    = 1'b0;
          ptr_d   = gid_q + 2'd1;
          state_d = ST_GAP;
        end else if (cnt_q < QMAX) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        if (any) begin
          gnt_d   = NREQ'(1) << pick;
          gv_d    = 1'b1;
          gid_d   = pick;
          cnt_d   = CW'(1);
          state_d = ST_GRANT;
        end else begin
          gnt_d   = '0;
          gv_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and output registers; EN freezes everything, CDN clears at once.
  always_ff @(posedge CK or negedge CDN) begin
    if (!CDN) begin
      state_q <= ST_IDLE;
      ptr_q   <= PTR_RST;
      cnt_q   <= '0;
      gnt_q   <= '0;
      gv_q    <= 1'b0;
      gid_q   <= '0;
    end else if (EN) begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      gv_q    <= gv_d;
      gid_q   <= gid_d;
    end
  end

  assign GNT = gnt_q;
  assign GV  = gv_q;
  assign GID = gid_q;

endmodule
